// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction
// fetch requester (I) and a load/store requester (D).
//
// Handshake (both requesters): a requester raises req with its payload and
// holds the payload stable until the cycle in which gnt (or, for D, err) is
// high. gnt/err are combinational and only ever asserted in IDLE. For reads,
// rvalid and rdata follow exactly one cycle after gnt. Stores take effect in
// the gnt cycle and have no response cycle.
module mem_port_arbiter #(
  parameter bit FIRST_PRIO  = 1'b1,  // 1 = D wins the first conflict, 0 = I
  parameter bit CHECK_ALIGN = 1'b1   // 1 = reject misaligned D accesses
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_err,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_I_RESP = 2'd1,
    ST_D_RESP = 2'd2
  } state_e;

  localparam logic [2:0] F3_WORD = 3'b010;

  state_e      state_q, state_d;
  // 1 = D wins the next I/D conflict. Seeded from FIRST_PRIO, and after each
  // grant it points at the requester that did not just win.
  logic        d_first_q, d_first_d;
  // Address/funct3 of the read in flight; the memory extracts bytes/halves
  // combinationally from these during the response cycle.
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;

  logic        d_f3_bad;
  logic        d_misal;
  logic        d_bad;
  logic        gnt_i;
  logic        gnt_d;

  assign dbg_state = state_q;

  // Classify the D request: illegal funct3 for its direction, or misaligned.
  always_comb begin
    d_f3_bad = 1'b0;
    d_misal  = 1'b0;
    if (d_we) begin
      d_f3_bad = !(d_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      d_f3_bad = d_funct3 inside {3'b011, 3'b110, 3'b111};
    end
    if (CHECK_ALIGN) begin
      unique case (d_funct3[1:0])
        2'b01:   d_misal = d_addr[0];
        2'b10:   d_misal = |d_addr[1:0];
        default: d_misal = 1'b0;
      endcase
    end
  end

  assign d_bad = d_f3_bad | d_misal;

  // Arbitration in IDLE; an erroring D request is not eligible, so I proceeds.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (state_q == ST_IDLE && !reset) begin
      if (i_req && d_req && !d_bad) begin
        gnt_d = d_first_q;
        gnt_i = !d_first_q;
      end else begin
        gnt_i = i_req;
        gnt_d = d_req && !d_bad;
      end
    end
  end

  // State, priority pointer and read-holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      d_first_q <= FIRST_PRIO;
      addr_q    <= 32'd0;
      f3_q      <= F3_WORD;
    end else begin
      state_q   <= state_d;
      d_first_q <= d_first_d;
      addr_q    <= addr_d;
      f3_q      <= f3_d;
    end
  end

  // Next state: a read grant opens a one-cycle response; stores stay in IDLE.
  always_comb begin
    state_d   = state_q;
    d_first_d = d_first_q;
    addr_d    = addr_q;
    f3_d      = f3_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_i) begin
          state_d   = ST_I_RESP;
          d_first_d = 1'b1;
          addr_d    = i_addr;
          f3_d      = F3_WORD;
        end else if (gnt_d) begin
          d_first_d = 1'b0;
          if (!d_we) begin
            state_d = ST_D_RESP;
            addr_d  = d_addr;
            f3_d    = d_funct3;
          end
        end
      end
      ST_I_RESP, ST_D_RESP: state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // Outputs: grants and memory drive in IDLE, held address/funct3 in RESP.
  always_comb begin
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    d_err      = 1'b0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    mem_write  = 1'b0;
    mem_raddr  = addr_q;
    mem_funct3 = f3_q;
    mem_waddr  = d_addr;
    mem_wdata  = d_wdata;
    i_rdata    = mem_rdata;
    d_rdata    = mem_rdata;
    unique case (state_q)
      ST_IDLE: begin
        i_gnt     = gnt_i;
        d_gnt     = gnt_d;
        d_err     = d_req && d_bad && !reset;
        mem_write = gnt_d && d_we && !reset;
        if (gnt_i) begin
          mem_raddr  = i_addr;
          mem_funct3 = F3_WORD;
        end else if (gnt_d) begin
          mem_raddr  = d_addr;
          mem_funct3 = d_funct3;
        end
      end
      ST_I_RESP: i_rvalid = 1'b1;
      ST_D_RESP: d_rvalid = 1'b1;
      default: ;
    endcase
  end

endmodule
